// File: rtl/pwm_multi_if.sv
`default_nettype none
// ============================================================================
// Module   : pwm_multi_if
// Purpose  : Control and output bundle for the multi-channel PWM generator.
// Revision : 1.0  initial release
// ============================================================================
interface pwm_multi_if #(
    parameter int CH = 2,
    parameter int CW = 8
);
    logic               en;
    logic               load;
    logic [CW-1:0]      period;
    logic [CH*CW-1:0]   duty;
    logic               mode;
    logic [CH-1:0]      inv;
    logic [CH-1:0]      PWM;
    logic [CW-1:0]      counter;
    logic [1:0]         state;
    logic               cycle_done;

    modport master (
        output en, load, period, duty, mode, inv,
        input  PWM, counter, state, cycle_done
    );

    modport slave (
        input  en, load, period, duty, mode, inv,
        output PWM, counter, state, cycle_done
    );
endinterface
`default_nettype wire

// File: rtl/pwm_multi.sv
`default_nettype none
// ============================================================================
// Module   : pwm_multi
// Purpose  : Multi-channel edge/centre-aligned PWM with double-buffered config.
// Revision : 1.0  initial release
// ============================================================================
module pwm_multi #(
    parameter int CH         = 2,
    parameter int CW         = 8,
    parameter int DEF_PERIOD = 20,
    parameter int DEF_DUTY   = 2
) (
    input  logic            clk1ms,
    input  logic            reset,
    pwm_multi_if.slave      bus
);

    localparam logic [CW-1:0] c_def_period = CW'(DEF_PERIOD);
    localparam logic [CW-1:0] c_def_duty   = CW'(DEF_DUTY);
    localparam logic [CW-1:0] c_min_period = CW'(2);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        UP   = 2'b01,
        DOWN = 2'b10
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CW-1:0]      r_counter;
    logic [CW-1:0]      w_counter_nxt;
    logic [CH-1:0]      r_pwm;
    logic [CH-1:0]      w_pwm_nxt;
    logic [CH-1:0]      w_raw;

    logic [CW-1:0]      r_act_period;
    logic [CH*CW-1:0]   r_act_duty;
    logic               r_act_mode;
    logic [CW-1:0]      r_pend_period;
    logic [CH*CW-1:0]   r_pend_duty;
    logic               r_pend_mode;

    logic [CW-1:0]      w_pend_period_nxt;
    logic [CH*CW-1:0]   w_pend_duty_nxt;
    logic               w_pend_mode_nxt;
    logic [CW-1:0]      w_act_period_nxt;
    logic [CH*CW-1:0]   w_act_duty_nxt;
    logic               w_act_mode_nxt;

    logic [CW-1:0]      w_pe;
    logic               w_at_top;
    logic               w_apply;
    logic               w_cycle_done;

    // A load on a boundary cycle must win, so the boundary copies from the
    // post-load pending view rather than the registered one.
    assign w_pend_period_nxt = bus.load ? bus.period : r_pend_period;
    assign w_pend_duty_nxt   = bus.load ? bus.duty   : r_pend_duty;
    assign w_pend_mode_nxt   = bus.load ? bus.mode   : r_pend_mode;

    assign w_act_period_nxt  = w_apply ? w_pend_period_nxt : r_act_period;
    assign w_act_duty_nxt    = w_apply ? w_pend_duty_nxt   : r_act_duty;
    assign w_act_mode_nxt    = w_apply ? w_pend_mode_nxt   : r_act_mode;

    assign w_pe     = (r_act_period < c_min_period) ? c_min_period : r_act_period;
    assign w_at_top = (r_counter >= (w_pe - CW'(1)));

    assign w_cycle_done = ((r_state == UP) && !r_act_mode && w_at_top) ||
                          ((r_state == DOWN) && (r_counter == '0));

    always_comb begin
        w_state_nxt   = r_state;
        w_counter_nxt = r_counter;
        w_apply       = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_counter_nxt = '0;
                if (bus.en) begin
                    w_state_nxt = UP;
                    w_apply     = 1'b1;
                end
            end
            UP: begin
                if (w_at_top) begin
                    if (r_act_mode) begin
                        w_state_nxt   = DOWN;
                        w_counter_nxt = w_pe - CW'(2);
                    end else begin
                        w_apply       = 1'b1;
                        w_counter_nxt = '0;
                        w_state_nxt   = bus.en ? UP : IDLE;
                    end
                end else begin
                    w_counter_nxt = r_counter + CW'(1);
                end
            end
            DOWN: begin
                if (r_counter == '0) begin
                    w_apply = 1'b1;
                    if (!bus.en) begin
                        w_state_nxt   = IDLE;
                        w_counter_nxt = '0;
                    end else begin
                        // Staying centre-aligned skips the repeated zero;
                        // a switch to edge mode restarts from zero.
                        w_state_nxt   = UP;
                        w_counter_nxt = (w_pend_mode_nxt == r_act_mode) ? CW'(1) : '0;
                    end
                end else begin
                    w_counter_nxt = r_counter - CW'(1);
                end
            end
            default: begin
                w_state_nxt   = IDLE;
                w_counter_nxt = '0;
            end
        endcase
    end

    for (genvar gi = 0; gi < CH; gi++) begin : g_ch
        assign w_raw[gi] = (w_counter_nxt < w_act_duty_nxt[gi*CW +: CW]);
    end

    assign w_pwm_nxt = (w_state_nxt == IDLE) ? bus.inv : (w_raw ^ bus.inv);

    always_ff @(posedge clk1ms or negedge reset) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_counter     <= '0;
            r_pwm         <= '0;
            r_act_period  <= c_def_period;
            r_act_duty    <= {CH{c_def_duty}};
            r_act_mode    <= 1'b0;
            r_pend_period <= c_def_period;
            r_pend_duty   <= {CH{c_def_duty}};
            r_pend_mode   <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_counter     <= w_counter_nxt;
            r_pwm         <= w_pwm_nxt;
            r_act_period  <= w_act_period_nxt;
            r_act_duty    <= w_act_duty_nxt;
            r_act_mode    <= w_act_mode_nxt;
            r_pend_period <= w_pend_period_nxt;
            r_pend_duty   <= w_pend_duty_nxt;
            r_pend_mode   <= w_pend_mode_nxt;
        end
    end

    assign bus.PWM        = r_pwm;
    assign bus.counter    = r_counter;
    assign bus.state      = r_state;
    assign bus.cycle_done = w_cycle_done;

endmodule
`default_nettype wire

// File: tb/tb_pwm_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwm_multi
// Purpose  : Self-checking bench for pwm_multi using directed vectors.
// Revision : 1.0  initial release
// ============================================================================
module tb_pwm_multi;

    localparam int CH = 2;
    localparam int CW = 8;

    logic clk1ms = 1'b0;
    logic reset  = 1'b0;

    pwm_multi_if #(.CH(CH), .CW(CW)) bus ();

    pwm_multi #(
        .CH(CH), .CW(CW), .DEF_PERIOD(20), .DEF_DUTY(2)
    ) dut (
        .clk1ms (clk1ms),
        .reset  (reset),
        .bus    (bus)
    );

    always #5 clk1ms = ~clk1ms;

    typedef struct {
        logic [7:0] period;
        logic [7:0] d0;
        logic [7:0] d1;
        logic       mode;
        logic [1:0] inv;
        int         exp_len;
        int         exp_hi0;
        int         exp_hi1;
    } vec_t;

    vec_t vecs [7];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Samples 1 time unit after the rising edge; load is a one-cycle strobe.
    task automatic tick();
        @(posedge clk1ms);
        #1;
        bus.load = 1'b0;
    endtask

    task automatic wait_cd();
        int n = 0;
        do begin
            tick();
            n++;
        end while (!bus.cycle_done && n < 600);
        if (!bus.cycle_done) chk("cycle_done_timeout", int'(bus.cycle_done), 1);
    endtask

    task automatic wait_counter(input int v);
        int n = 0;
        do begin
            tick();
            n++;
        end while (int'(bus.counter) != v && n < 600);
        if (int'(bus.counter) != v) chk("counter_timeout", int'(bus.counter), v);
    endtask

    task automatic measure(output int len, output int hi0, output int hi1);
        len = 0; hi0 = 0; hi1 = 0;
        do begin
            tick();
            len++;
            hi0 += int'(bus.PWM[0]);
            hi1 += int'(bus.PWM[1]);
        end while (!bus.cycle_done && len < 600);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int len, hi0, hi1;
        int exp_cnt [28];
        int exp_st  [28];

        vecs[0] = '{8'd20,  8'd2,   8'd18,  1'b0, 2'b00, 20, 2,  18};
        vecs[1] = '{8'd10,  8'd3,   8'd8,   1'b1, 2'b00, 18, 5,  15};
        vecs[2] = '{8'd20,  8'd0,   8'd255, 1'b0, 2'b00, 20, 0,  20};
        vecs[3] = '{8'd0,   8'd1,   8'd0,   1'b0, 2'b00, 2,  1,  0};
        vecs[4] = '{8'd20,  8'd2,   8'd18,  1'b0, 2'b11, 20, 18, 2};
        vecs[5] = '{8'd1,   8'd1,   8'd2,   1'b1, 2'b00, 2,  1,  2};
        vecs[6] = '{8'd6,   8'd6,   8'd0,   1'b1, 2'b10, 10, 10, 10};

        for (int k = 0; k < 10; k++) begin exp_cnt[k] = k;       exp_st[k] = 1; end
        for (int k = 0; k < 9;  k++) begin exp_cnt[10+k] = 8-k;  exp_st[10+k] = 2; end
        for (int k = 0; k < 9;  k++) begin exp_cnt[19+k] = k+1;  exp_st[19+k] = 1; end

        bus.en = 1'b0; bus.load = 1'b0; bus.period = 8'd20;
        bus.duty = '0; bus.mode = 1'b0; bus.inv = 2'b00;

        // Reset values while reset is held low
        #12;
        chk("rst_state",   int'(bus.state), 0);
        chk("rst_counter", int'(bus.counter), 0);
        chk("rst_pwm",     int'(bus.PWM), 0);
        chk("rst_cd",      int'(bus.cycle_done), 0);
        @(negedge clk1ms);
        reset = 1'b1;
        tick();
        chk("idle_state", int'(bus.state), 0);

        bus.inv = 2'b11;
        tick();
        chk("idle_inv_pwm", int'(bus.PWM), 3);
        chk("idle_cd",      int'(bus.cycle_done), 0);

        // Default edge run: period 20, duty 2 on both channels
        bus.inv = 2'b00;
        bus.en  = 1'b1;
        tick();
        chk("start_state", int'(bus.state), 1);
        for (int k = 0; k < 20; k++) begin
            chk($sformatf("def_cnt%0d", k), int'(bus.counter), k);
            chk($sformatf("def_pwm%0d", k), int'(bus.PWM), (k < 2) ? 3 : 0);
            chk($sformatf("def_cd%0d", k),  int'(bus.cycle_done), (k == 19) ? 1 : 0);
            tick();
        end
        chk("wrap_cnt", int'(bus.counter), 0);

        // Centre sequence P=10, D0=3 entered from edge mode
        bus.period = 8'd10; bus.duty = {8'd3, 8'd3}; bus.mode = 1'b1; bus.load = 1'b1;
        wait_cd();
        for (int k = 0; k < 28; k++) begin
            tick();
            chk($sformatf("ctr_cnt%0d", k), int'(bus.counter), exp_cnt[k]);
            chk($sformatf("ctr_st%0d", k),  int'(bus.state), exp_st[k]);
            chk($sformatf("ctr_cd%0d", k),  int'(bus.cycle_done),
                (exp_st[k] == 2 && exp_cnt[k] == 0) ? 1 : 0);
            chk($sformatf("ctr_pwm%0d", k), int'(bus.PWM[0]), (exp_cnt[k] < 3) ? 1 : 0);
        end

        // Table: steady-period length and per-channel high counts
        for (int i = 0; i < 7; i++) begin
            bus.period = vecs[i].period;
            bus.duty   = {vecs[i].d1, vecs[i].d0};
            bus.mode   = vecs[i].mode;
            bus.inv    = vecs[i].inv;
            bus.load   = 1'b1;
            wait_cd();
            wait_cd();
            measure(len, hi0, hi1);
            chk($sformatf("vec%0d_len", i), len, vecs[i].exp_len);
            chk($sformatf("vec%0d_hi0", i), hi0, vecs[i].exp_hi0);
            chk($sformatf("vec%0d_hi1", i), hi1, vecs[i].exp_hi1);
        end
        bus.inv = 2'b00;

        // Shadowing: mid-period load waits, boundary load applies at once
        bus.period = 8'd20; bus.duty = {8'd2, 8'd2}; bus.mode = 1'b0; bus.load = 1'b1;
        wait_cd();
        wait_cd();
        wait_counter(7);
        bus.duty = {8'd2, 8'd12}; bus.load = 1'b1;
        tick();
        for (int k = 8; k < 12; k++) begin
            chk($sformatf("shadow_hold%0d", k), int'(bus.PWM[0]), 0);
            tick();
        end
        wait_cd();
        measure(len, hi0, hi1);
        chk("shadow_new_hi0", hi0, 12);
        chk("shadow_len", len, 20);
        bus.duty = {8'd2, 8'd5}; bus.load = 1'b1;
        measure(len, hi0, hi1);
        chk("shadow_cd_hi0", hi0, 5);

        // Disable completes the period, then idles showing inv
        bus.inv = 2'b01;
        wait_counter(5);
        bus.en = 1'b0;
        wait_cd();
        chk("dis_last_cnt", int'(bus.counter), 19);
        chk("dis_last_st",  int'(bus.state), 1);
        tick();
        chk("dis_idle_st",  int'(bus.state), 0);
        chk("dis_idle_cnt", int'(bus.counter), 0);
        chk("dis_idle_pwm", int'(bus.PWM), 1);
        chk("dis_idle_cd",  int'(bus.cycle_done), 0);
        tick();
        chk("dis_idle2_st", int'(bus.state), 0);
        bus.en = 1'b1;
        tick();
        chk("restart_st",  int'(bus.state), 1);
        chk("restart_cnt", int'(bus.counter), 0);
        chk("restart_pwm", int'(bus.PWM), 2);

        // en re-asserted before the boundary cancels the stop
        wait_counter(5);
        bus.en = 1'b0;
        wait_counter(10);
        bus.en = 1'b1;
        wait_cd();
        tick();
        chk("cancel_st",  int'(bus.state), 1);
        chk("cancel_cnt", int'(bus.counter), 0);
        bus.inv = 2'b00;

        // Asynchronous reset mid-run also discards a pending load
        wait_counter(11);
        bus.period = 8'd10; bus.duty = {8'd7, 8'd7}; bus.mode = 1'b1; bus.load = 1'b1;
        tick();
        #3;
        reset = 1'b0;
        #1;
        chk("arst_state", int'(bus.state), 0);
        chk("arst_cnt",   int'(bus.counter), 0);
        chk("arst_pwm",   int'(bus.PWM), 0);
        chk("arst_cd",    int'(bus.cycle_done), 0);
        @(negedge clk1ms);
        reset = 1'b1;
        tick();
        for (int k = 0; k < 20; k++) begin
            chk($sformatf("post_cnt%0d", k), int'(bus.counter), k);
            chk($sformatf("post_pwm%0d", k), int'(bus.PWM), (k < 2) ? 3 : 0);
            chk($sformatf("post_cd%0d", k),  int'(bus.cycle_done), (k == 19) ? 1 : 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pwm_multi.md
Name: pwm_multi

Overview:
- Parametrised multi-channel PWM generator; successor to the single-channel fixed 2/18 PWM FSM.
- One shared period counter drives CH channels, each with its own duty threshold and output polarity.
- Supports edge-aligned and centre-aligned modes.
- Period, duty and mode are double-buffered and take effect only at a period boundary, so outputs never glitch.
- Sits between the control/register logic and the actuator pins, clocked by clk1ms.

Parameters:
- CH, 2, number of PWM channels.
- CW, 8, width of the counter, period and each duty value.
- DEF_PERIOD, 20, period value loaded at reset.
- DEF_DUTY, 2, duty value loaded into every channel at reset.

Ports:
- clk1ms  input  1  system tick clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- en  input  1  run enable.
- load  input  1  one-cycle strobe that captures period, duty and mode into the pending registers.
- period  input  CW  requested period value P.
- duty  input  CH*CW  requested duties; channel i is at bits [i*CW +: CW].
- mode  input  1  0 = edge-aligned, 1 = centre-aligned.
- inv  input  CH  per-channel output inversion; applied live, not buffered.
- PWM  output  CH  registered PWM outputs.
- counter  output  CW  current counter value.
- state  output  2  FSM state: IDLE=00, UP=01, DOWN=10.
- cycle_done  output  1  one-cycle pulse on the last clock of each period.

Behaviour:
- Reset (reset low, asynchronous)
  - state=IDLE, counter=0, PWM=0, cycle_done=0.
  - Active and pending period/duty take DEF_PERIOD/DEF_DUTY; mode=0.
  - Takes effect immediately, including mid-period; there is no partial-period completion.
- Effective period Pe = max(P,2); any period value below 2 is clamped to 2.
- Channel raw level: raw_i = (counter < D_i).
  - D_i=0 gives constant low.
  - D_i >= Pe gives constant high.
  - Comparison is unsigned, CW bits.
- PWM[i] = raw_i XOR inv[i].
  - PWM is registered from the next-state counter, so PWM in a cycle always reflects the counter value shown in that same cycle.
  - In IDLE, PWM[i] = inv[i].
- Shadowing
  - load=1 copies period/duty/mode into the pending registers.
  - Pending values are copied into the active registers at every boundary: the cycle_done cycle, or the IDLE->UP transition.
  - If load coincides with a boundary, the newly loaded values are the ones applied.
  - A load mid-period changes nothing until the next boundary; the last load before a boundary wins.
- Edge mode
  - State is UP; counter runs 0,1,...,Pe-1 and then wraps to 0.
  - cycle_done=1 while counter==Pe-1.
  - Period length is Pe clocks.
- Centre mode
  - UP: counter increments; at counter==Pe-1 go to DOWN with counter Pe-2 next.
  - DOWN: counter decrements; at counter==0 assert cycle_done and go to UP with counter 1 next.
  - Steady-state period is 2*Pe-2 clocks. The first period after IDLE starts at 0 and is one clock longer.
- Mode switch is applied only at a boundary. The new mode starts in UP with counter=0.
- IDLE -> UP: when en=1; counter=0 on the next cycle.
- en=0 while running: the current period completes, then the FSM enters IDLE at the boundary (counter=0). en re-asserted before that boundary cancels the stop.
- cycle_done is never asserted in IDLE.

Test Plan:
- Edge, CH=2, P=20, D={18,2}, inv=0, en=1
  - PWM[0] high for counter 0..1 (2 of 20 clocks).
  - PWM[1] high for 18 of 20 clocks.
  - cycle_done every 20 clocks at counter=19.
- Centre, P=10, D0=3
  - Counter sequence: UP 0..9, then DOWN 8..0, then UP 1..9.
  - Steady period is 18 clocks; PWM[0] high for 5 contiguous clocks (2,1,0,1,2) per period.
  - cycle_done at DOWN counter=0.
- Shadow: in edge mode with P=20, load D0=5 at counter=7
  - PWM[0] keeps the 2-clock width for the rest of that period.
  - 5-clock width starts at the next counter=0.
  - Repeat with load on the cycle_done cycle: the new width applies immediately.
- Boundaries
  - D0=0 gives constant 0; D1=255 gives constant 1.
  - P=0 behaves as P=2: counter toggles 0,1 and cycle_done every 2 clocks.
  - inv=2'b11 flips both outputs, including in IDLE.
- Disable: drop en at counter=5 with P=20
  - Run continues to counter=19 with cycle_done, then state=IDLE, counter=0, PWM=inv.
  - Raising en again restarts at counter 0.
- Reset mid-run: assert reset low at counter=12, asynchronously to clk1ms
  - Outputs go to 0 and state=IDLE immediately.
  - After release, period 20 and duty 2 are active with no load.
